// File: rtl/counter_rom_main2.sv
`default_nettype none
// ============================================================================
// Module   : counter_rom_main2
// Purpose  : 8-bit enabled up-counter that scans a 256 x 3 popcount ROM.
// Revision : 1.0 - initial release
// ============================================================================

module counter_8bit_enable (
  input  logic       clk,
  input  logic       reset,
  input  logic       count_enb,
  output logic [7:0] count
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'h00;
    end else if (count_enb) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count = r_count;

endmodule

// Each entry is the number of set bits in the address, clipped to 7 (only 8'hFF clips).
module rom_main2 (
  input  logic [7:0] a,
  output logic [2:0] b
);

  always_comb begin
    b = 3'd0;
    case (a)
      8'h00: b = 3'd0; 8'h01: b = 3'd1; 8'h02: b = 3'd1; 8'h03: b = 3'd2; 8'h04: b = 3'd1; 8'h05: b = 3'd2; 8'h06: b = 3'd2; 8'h07: b = 3'd3;
      8'h08: b = 3'd1; 8'h09: b = 3'd2; 8'h0A: b = 3'd2; 8'h0B: b = 3'd3; 8'h0C: b = 3'd2; 8'h0D: b = 3'd3; 8'h0E: b = 3'd3; 8'h0F: b = 3'd4;
      8'h10: b = 3'd1; 8'h11: b = 3'd2; 8'h12: b = 3'd2; 8'h13: b = 3'd3; 8'h14: b = 3'd2; 8'h15: b = 3'd3; 8'h16: b = 3'd3; 8'h17: b = 3'd4;
      8'h18: b = 3'd2; 8'h19: b = 3'd3; 8'h1A: b = 3'd3; 8'h1B: b = 3'd4; 8'h1C: b = 3'd3; 8'h1D: b = 3'd4; 8'h1E: b = 3'd4; 8'h1F: b = 3'd5;
      8'h20: b = 3'd1; 8'h21: b = 3'd2; 8'h22: b = 3'd2; 8'h23: b = 3'd3; 8'h24: b = 3'd2; 8'h25: b = 3'd3; 8'h26: b = 3'd3; 8'h27: b = 3'd4;
      8'h28: b = 3'd2; 8'h29: b = 3'd3; 8'h2A: b = 3'd3; 8'h2B: b = 3'd4; 8'h2C: b = 3'd3; 8'h2D: b = 3'd4; 8'h2E: b = 3'd4; 8'h2F: b = 3'd5;
      8'h30: b = 3'd2; 8'h31: b = 3'd3; 8'h32: b = 3'd3; 8'h33: b = 3'd4; 8'h34: b = 3'd3; 8'h35: b = 3'd4; 8'h36: b = 3'd4; 8'h37: b = 3'd5;
      8'h38: b = 3'd3; 8'h39: b = 3'd4; 8'h3A: b = 3'd4; 8'h3B: b = 3'd5; 8'h3C: b = 3'd4; 8'h3D: b = 3'd5; 8'h3E: b = 3'd5; 8'h3F: b = 3'd6;
      8'h40: b = 3'd1; 8'h41: b = 3'd2; 8'h42: b = 3'd2; 8'h43: b = 3'd3; 8'h44: b = 3'd2; 8'h45: b = 3'd3; 8'h46: b = 3'd3; 8'h47: b = 3'd4;
      8'h48: b = 3'd2; 8'h49: b = 3'd3; 8'h4A: b = 3'd3; 8'h4B: b = 3'd4; 8'h4C: b = 3'd3; 8'h4D: b = 3'd4; 8'h4E: b = 3'd4; 8'h4F: b = 3'd5;
      8'h50: b = 3'd2; 8'h51: b = 3'd3; 8'h52: b = 3'd3; 8'h53: b = 3'd4; 8'h54: b = 3'd3; 8'h55: b = 3'd4; 8'h56: b = 3'd4; 8'h57: b = 3'd5;
      8'h58: b = 3'd3; 8'h59: b = 3'd4; 8'h5A: b = 3'd4; 8'h5B: b = 3'd5; 8'h5C: b = 3'd4; 8'h5D: b = 3'd5; 8'h5E: b = 3'd5; 8'h5F: b = 3'd6;
      8'h60: b = 3'd2; 8'h61: b = 3'd3; 8'h62: b = 3'd3; 8'h63: b = 3'd4; 8'h64: b = 3'd3; 8'h65: b = 3'd4; 8'h66: b = 3'd4; 8'h67: b = 3'd5;
      8'h68: b = 3'd3; 8'h69: b = 3'd4; 8'h6A: b = 3'd4; 8'h6B: b = 3'd5; 8'h6C: b = 3'd4; 8'h6D: b = 3'd5; 8'h6E: b = 3'd5; 8'h6F: b = 3'd6;
      8'h70: b = 3'd3; 8'h71: b = 3'd4; 8'h72: b = 3'd4; 8'h73: b = 3'd5; 8'h74: b = 3'd4; 8'h75: b = 3'd5; 8'h76: b = 3'd5; 8'h77: b = 3'd6;
      8'h78: b = 3'd4; 8'h79: b = 3'd5; 8'h7A: b = 3'd5; 8'h7B: b = 3'd6; 8'h7C: b = 3'd5; 8'h7D: b = 3'd6; 8'h7E: b = 3'd6; 8'h7F: b = 3'd7;
      8'h80: b = 3'd1; 8'h81: b = 3'd2; 8'h82: b = 3'd2; 8'h83: b = 3'd3; 8'h84: b = 3'd2; 8'h85: b = 3'd3; 8'h86: b = 3'd3; 8'h87: b = 3'd4;
      8'h88: b = 3'd2; 8'h89: b = 3'd3; 8'h8A: b = 3'd3; 8'h8B: b = 3'd4; 8'h8C: b = 3'd3; 8'h8D: b = 3'd4; 8'h8E: b = 3'd4; 8'h8F: b = 3'd5;
      8'h90: b = 3'd2; 8'h91: b = 3'd3; 8'h92: b = 3'd3; 8'h93: b = 3'd4; 8'h94: b = 3'd3; 8'h95: b = 3'd4; 8'h96: b = 3'd4; 8'h97: b = 3'd5;
      8'h98: b = 3'd3; 8'h99: b = 3'd4; 8'h9A: b = 3'd4; 8'h9B: b = 3'd5; 8'h9C: b = 3'd4; 8'h9D: b = 3'd5; 8'h9E: b = 3'd5; 8'h9F: b = 3'd6;
      8'hA0: b = 3'd2; 8'hA1: b = 3'd3; 8'hA2: b = 3'd3; 8'hA3: b = 3'd4; 8'hA4: b = 3'd3; 8'hA5: b = 3'd4; 8'hA6: b = 3'd4; 8'hA7: b = 3'd5;
      8'hA8: b = 3'd3; 8'hA9: b = 3'd4; 8'hAA: b = 3'd4; 8'hAB: b = 3'd5; 8'hAC: b = 3'd4; 8'hAD: b = 3'd5; 8'hAE: b = 3'd5; 8'hAF: b = 3'd6;
      8'hB0: b = 3'd3; 8'hB1: b = 3'd4; 8'hB2: b = 3'd4; 8'hB3: b = 3'd5; 8'hB4: b = 3'd4; 8'hB5: b = 3'd5; 8'hB6: b = 3'd5; 8'hB7: b = 3'd6;
      8'hB8: b = 3'd4; 8'hB9: b = 3'd5; 8'hBA: b = 3'd5; 8'hBB: b = 3'd6; 8'hBC: b = 3'd5; 8'hBD: b = 3'd6; 8'hBE: b = 3'd6; 8'hBF: b = 3'd7;
      8'hC0: b = 3'd2; 8'hC1: b = 3'd3; 8'hC2: b = 3'd3; 8'hC3: b = 3'd4; 8'hC4: b = 3'd3; 8'hC5: b = 3'd4; 8'hC6: b = 3'd4; 8'hC7: b = 3'd5;
      8'hC8: b = 3'd3; 8'hC9: b = 3'd4; 8'hCA: b = 3'd4; 8'hCB: b = 3'd5; 8'hCC: b = 3'd4; 8'hCD: b = 3'd5; 8'hCE: b = 3'd5; 8'hCF: b = 3'd6;
      8'hD0: b = 3'd3; 8'hD1: b = 3'd4; 8'hD2: b = 3'd4; 8'hD3: b = 3'd5; 8'hD4: b = 3'd4; 8'hD5: b = 3'd5; 8'hD6: b = 3'd5; 8'hD7: b = 3'd6;
      8'hD8: b = 3'd4; 8'hD9: b = 3'd5; 8'hDA: b = 3'd5; 8'hDB: b = 3'd6; 8'hDC: b = 3'd5; 8'hDD: b = 3'd6; 8'hDE: b = 3'd6; 8'hDF: b = 3'd7;
      8'hE0: b = 3'd3; 8'hE1: b = 3'd4; 8'hE2: b = 3'd4; 8'hE3: b = 3'd5; 8'hE4: b = 3'd4; 8'hE5: b = 3'd5; 8'hE6: b = 3'd5; 8'hE7: b = 3'd6;
      8'hE8: b = 3'd4; 8'hE9: b = 3'd5; 8'hEA: b = 3'd5; 8'hEB: b = 3'd6; 8'hEC: b = 3'd5; 8'hED: b = 3'd6; 8'hEE: b = 3'd6; 8'hEF: b = 3'd7;
      8'hF0: b = 3'd4; 8'hF1: b = 3'd5; 8'hF2: b = 3'd5; 8'hF3: b = 3'd6; 8'hF4: b = 3'd5; 8'hF5: b = 3'd6; 8'hF6: b = 3'd6; 8'hF7: b = 3'd7;
      8'hF8: b = 3'd5; 8'hF9: b = 3'd6; 8'hFA: b = 3'd6; 8'hFB: b = 3'd7; 8'hFC: b = 3'd6; 8'hFD: b = 3'd7; 8'hFE: b = 3'd7; 8'hFF: b = 3'd7;
      default: b = 3'd0;
    endcase
  end

endmodule

module counter_rom_main2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       count_enb,
  output logic [7:0] count,
  output logic [2:0] b
);

  logic [7:0] w_count;

  counter_8bit_enable u_counter (
    .clk       (clk),
    .reset     (reset),
    .count_enb (count_enb),
    .count     (w_count)
  );

  rom_main2 u_rom (
    .a (w_count),
    .b (b)
  );

  assign count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_counter_rom_main2.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_rom_main2
// Purpose  : Directed scoreboard bench for the counter/ROM scanner.
// Revision : 1.0 - initial release
// ============================================================================

module tb_counter_rom_main2;

  typedef struct packed {
    logic [7:0] cnt;
    logic [2:0] dat;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       count_enb;
  logic [7:0] count;
  logic [2:0] b;

  exp_t       q_exp[$];
  logic [7:0] m_count;
  int         checks;
  int         errors;

  counter_rom_main2 dut (
    .clk       (clk),
    .reset     (reset),
    .count_enb (count_enb),
    .count     (count),
    .b         (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] popsat(input logic [7:0] v);
    int n;
    n = $countones(v);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict the post-edge outputs, then score them.
  task automatic step(input logic rst, input logic en);
    exp_t e;
    reset     = rst;
    count_enb = en;
    if (rst)     m_count = 8'h00;
    else if (en) m_count = m_count + 8'd1;
    q_exp.push_back('{cnt: m_count, dat: popsat(m_count)});
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    chk8("count", count, e.cnt);
    chk3("b", b, e.dat);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_count   = 8'h00;
    reset     = 1'b1;
    count_enb = 1'b1;
    #1;

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    chk8("reset_count", count, 8'h00);
    chk3("reset_b", b, 3'd0);

    // Sweep from 01 around the wrap back to 00.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    chk8("sweep_07", count, 8'h07);
    chk3("b_at_07", b, 3'd3);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    chk3("b_at_0F", b, 3'd4);
    for (int i = 0; i < 239; i++) step(1'b0, 1'b1);
    chk8("pre_FE", count, 8'hFE);
    chk3("b_at_FE", b, 3'd7);
    step(1'b0, 1'b1);
    chk3("b_at_FF", b, 3'd7);
    step(1'b0, 1'b1);
    chk8("wrap_00", count, 8'h00);
    chk3("wrap_b", b, 3'd0);

    for (int i = 0; i < 42; i++) step(1'b0, 1'b1);
    chk8("at_2A", count, 8'h2A);
    chk3("b_at_2A", b, 3'd3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk8("hold_count", count, 8'h2A);
    chk3("hold_b", b, 3'd3);
    step(1'b0, 1'b1);
    chk8("resume_2B", count, 8'h2B);
    chk3("b_at_2B", b, 3'd4);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    chk8("mid_08", count, 8'h08);
    step(1'b1, 1'b1);
    chk8("mid_reset_first_edge", count, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk8("post_reset_01", count, 8'h01);
    step(1'b0, 1'b1);
    chk8("post_reset_02", count, 8'h02);

    for (int i = 0; i < 126; i++) step(1'b0, 1'b1);
    chk8("at_80", count, 8'h80);
    step(1'b1, 1'b1);
    chk8("reset_beats_enable", count, 8'h00);
    chk3("reset_beats_enable_b", b, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
